// File: rtl/id_exe_pkg.sv
// Shared types for the ID->EXE pipeline register: payload bundle and occupancy state.
// Payload widths mirror the default module parameters.
package id_exe_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;

  typedef struct packed {
    logic              wb_en;
    logic [REG_AW-1:0] rd_addr;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/id_exe_fwd_patch.sv
// Combinational write-back forwarding: overwrites rs1/rs2 data of one payload
// when its source address matches a non-zero write-back address.
module id_exe_fwd_patch
  import id_exe_pkg::*;
(
  input  id_ex_payload_t    pay_i,
  input  logic              en_i,
  input  logic [REG_AW-1:0] addr_i,
  input  logic [XLEN-1:0]   data_i,
  output id_ex_payload_t    pay_o
);

  always_comb begin
    pay_o = pay_i;
    if (en_i && (addr_i != '0)) begin
      if (pay_i.rs1_addr == addr_i) pay_o.rs1_data = data_i;
      if (pay_i.rs2_addr == addr_i) pay_o.rs2_data = data_i;
    end
  end

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register with valid/ready handshake, 2-entry skid, synchronous flush.
// Optional write-back forwarding into held entries when ID_EXE_WB_FWD_EN is defined.
module id_exe_pipe_reg
  import id_exe_pkg::*;
#(
  parameter int XLEN   = id_exe_pkg::XLEN,
  parameter int REG_AW = id_exe_pkg::REG_AW,
  parameter int CTRL_W = id_exe_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
`ifdef ID_EXE_WB_FWD_EN
  input  logic              wb_fwd_en,
  input  logic [REG_AW-1:0] wb_fwd_addr,
  input  logic [XLEN-1:0]   wb_fwd_data,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_id,
  input  logic [REG_AW-1:0] rd_addr_id,
  input  logic [REG_AW-1:0] rs1_addr_id,
  input  logic [REG_AW-1:0] rs2_addr_id,
  input  logic [XLEN-1:0]   rs1_data_id,
  input  logic [XLEN-1:0]   rs2_data_id,
  input  logic [XLEN-1:0]   imm_id,
  input  logic [XLEN-1:0]   pc_id,
  input  logic [CTRL_W-1:0] ctrl_id,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en_ex,
  output logic [REG_AW-1:0] rd_addr_ex,
  output logic [REG_AW-1:0] rs1_addr_ex,
  output logic [REG_AW-1:0] rs2_addr_ex,
  output logic [XLEN-1:0]   rs1_data_ex,
  output logic [XLEN-1:0]   rs2_data_ex,
  output logic [XLEN-1:0]   imm_ex,
  output logic [XLEN-1:0]   pc_ex,
  output logic [CTRL_W-1:0] ctrl_ex
);

  pipe_state_e    state_q, state_d;
  id_ex_payload_t main_q, main_d, skid_q, skid_d;
  id_ex_payload_t in_raw, in_p, main_cur, skid_cur;
  logic           accept, take;

  assign in_raw = '{wb_en:    wb_en_id,
                    rd_addr:  rd_addr_id,
                    rs1_addr: rs1_addr_id,
                    rs2_addr: rs2_addr_id,
                    rs1_data: rs1_data_id,
                    rs2_data: rs2_data_id,
                    imm:      imm_id,
                    pc:       pc_id,
                    ctrl:     ctrl_id};

`ifdef ID_EXE_WB_FWD_EN
  // Only occupied entries are patched; stale contents stay untouched.
  id_exe_fwd_patch u_patch_in (
    .pay_i(in_raw), .en_i(wb_fwd_en), .addr_i(wb_fwd_addr), .data_i(wb_fwd_data), .pay_o(in_p)
  );
  id_exe_fwd_patch u_patch_main (
    .pay_i(main_q), .en_i(wb_fwd_en && (state_q != EMPTY)), .addr_i(wb_fwd_addr),
    .data_i(wb_fwd_data), .pay_o(main_cur)
  );
  id_exe_fwd_patch u_patch_skid (
    .pay_i(skid_q), .en_i(wb_fwd_en && (state_q == FULL)), .addr_i(wb_fwd_addr),
    .data_i(wb_fwd_data), .pay_o(skid_cur)
  );
`else
  assign in_p     = in_raw;
  assign main_cur = main_q;
  assign skid_cur = skid_q;
`endif

  // Handshake flags come straight from the state flops: no out_ready -> in_ready path.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_cur;
    skid_d  = skid_cur;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          state_d = ONE;
          main_d  = in_p;
        end
        ONE: begin
          if (accept && take) begin
            main_d = in_p;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_p;
          end else if (take) begin
            state_d = EMPTY;
          end
        end
        FULL: if (take) begin
          state_d = ONE;
          main_d  = skid_cur;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign wb_en_ex    = main_q.wb_en && out_valid;
  assign rd_addr_ex  = main_q.rd_addr;
  assign rs1_addr_ex = main_q.rs1_addr;
  assign rs2_addr_ex = main_q.rs2_addr;
  assign rs1_data_ex = main_q.rs1_data;
  assign rs2_data_ex = main_q.rs2_data;
  assign imm_ex      = main_q.imm;
  assign pc_ex       = main_q.pc;
  assign ctrl_ex     = main_q.ctrl;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Randomized and directed bench for id_exe_pipe_reg against a queue-based reference model.
module tb_id_exe_pipe_reg;
  import id_exe_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush, in_valid, in_ready, wb_en_id, out_valid, out_ready, wb_en_ex;
  logic [REG_AW-1:0] rd_addr_id, rs1_addr_id, rs2_addr_id, rd_addr_ex, rs1_addr_ex, rs2_addr_ex;
  logic [XLEN-1:0]   rs1_data_id, rs2_data_id, imm_id, pc_id;
  logic [XLEN-1:0]   rs1_data_ex, rs2_data_ex, imm_ex, pc_ex;
  logic [CTRL_W-1:0] ctrl_id, ctrl_ex;
`ifdef ID_EXE_WB_FWD_EN
  logic              wb_fwd_en;
  logic [REG_AW-1:0] wb_fwd_addr;
  logic [XLEN-1:0]   wb_fwd_data;
`endif

  always #5 clk = ~clk;

  id_exe_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
`ifdef ID_EXE_WB_FWD_EN
    .wb_fwd_en(wb_fwd_en), .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .wb_en_id(wb_en_id), .rd_addr_id(rd_addr_id),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id), .rs1_data_id(rs1_data_id),
    .rs2_data_id(rs2_data_id), .imm_id(imm_id), .pc_id(pc_id), .ctrl_id(ctrl_id),
    .out_valid(out_valid), .out_ready(out_ready), .wb_en_ex(wb_en_ex), .rd_addr_ex(rd_addr_ex),
    .rs1_addr_ex(rs1_addr_ex), .rs2_addr_ex(rs2_addr_ex), .rs1_data_ex(rs1_data_ex),
    .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex), .pc_ex(pc_ex), .ctrl_ex(ctrl_ex)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: in-order queue of at most two entries plus the last shown payload.
  id_ex_payload_t mq[$];
  id_ex_payload_t shown;
  logic [XLEN-1:0] taken[$];

  function automatic id_ex_payload_t incoming();
    id_ex_payload_t p;
    p.wb_en = wb_en_id;   p.rd_addr = rd_addr_id;
    p.rs1_addr = rs1_addr_id; p.rs2_addr = rs2_addr_id;
    p.rs1_data = rs1_data_id; p.rs2_data = rs2_data_id;
    p.imm = imm_id; p.pc = pc_id; p.ctrl = ctrl_id;
    return p;
  endfunction

  function automatic id_ex_payload_t fwd(id_ex_payload_t p);
    id_ex_payload_t r = p;
`ifdef ID_EXE_WB_FWD_EN
    if (wb_fwd_en && wb_fwd_addr != 0) begin
      if (p.rs1_addr == wb_fwd_addr) r.rs1_data = wb_fwd_data;
      if (p.rs2_addr == wb_fwd_addr) r.rs2_data = wb_fwd_data;
    end
`endif
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      shown = '0;
    end else begin
      bit acc, tk;
      id_ex_payload_t nx;
      acc = in_valid && (mq.size() < 2);
      tk  = (mq.size() > 0) && out_ready;
      nx  = fwd(incoming());
      foreach (mq[i]) mq[i] = fwd(mq[i]);
      if (mq.size() > 0) shown = mq[0];
      if (tk) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (acc) mq.push_back(nx);
      if (mq.size() > 0) shown = mq[0];
    end
  end

  // Compare process: every negative edge, DUT outputs against the model.
  always @(negedge clk) begin
    bit ev;
    ev = (mq.size() > 0);
    chk("out_valid", out_valid, ev);
    chk("in_ready", in_ready, mq.size() < 2);
    chk("wb_en_ex", wb_en_ex, ev & shown.wb_en);
    chk("pc_ex", pc_ex, shown.pc);
    chk("imm_ex", imm_ex, shown.imm);
    chk("rs1_data_ex", rs1_data_ex, shown.rs1_data);
    chk("rs2_data_ex", rs2_data_ex, shown.rs2_data);
    chk("addr_ctrl_ex", {rd_addr_ex, rs1_addr_ex, rs2_addr_ex, ctrl_ex},
        {shown.rd_addr, shown.rs1_addr, shown.rs2_addr, shown.ctrl});
    if (out_valid && out_ready) taken.push_back(pc_ex);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [XLEN-1:0] pc);
    in_valid    = 1'b1;
    pc_id       = pc;
    wb_en_id    = 1'($urandom_range(0, 1));
    rd_addr_id  = REG_AW'($urandom_range(0, 31));
    rs1_addr_id = REG_AW'($urandom_range(0, 7));
    rs2_addr_id = REG_AW'($urandom_range(0, 7));
    rs1_data_id = $urandom;
    rs2_data_id = $urandom;
    imm_id      = $urandom;
    ctrl_id     = CTRL_W'($urandom);
  endtask

  task automatic drain();
    int budget = 20;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (out_valid && budget > 0) begin
      step();
      budget--;
    end
    chk("drain_timeout", out_valid, 1'b0);
  endtask

  initial begin
    int n, found;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    wb_en_id = 1'b0; rd_addr_id = '0; rs1_addr_id = '0; rs2_addr_id = '0;
    rs1_data_id = '0; rs2_data_id = '0; imm_id = '0; pc_id = '0; ctrl_id = '0;
`ifdef ID_EXE_WB_FWD_EN
    wb_fwd_en = 1'b0; wb_fwd_addr = '0; wb_fwd_data = '0;
`endif
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_pc_ex", pc_ex, 0);
    chk("rst_wb_en_ex", wb_en_ex, 0);
    rst = 1'b0;

    // Streaming at full rate
    taken.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(32'h100 + 32'(4 * i));
      step();
      chk("stream_in_ready", in_ready, 1);
      chk("stream_out_valid", out_valid, 1);
      chk("stream_pc", pc_ex, 32'h100 + 32'(4 * i));
    end
    drain();
    chk("stream_count", taken.size(), 4);
    for (int i = 0; i < 4 && i < taken.size(); i++)
      chk("stream_order", taken[i], 32'h100 + 32'(4 * i));

    // Backpressure into the skid entry
    taken.delete();
    out_ready = 1'b0;
    send(32'h200); step();
    send(32'h204); step();
    in_valid = 1'b0;
    chk("bp_in_ready", in_ready, 0);
    chk("bp_pc_hold", pc_ex, 32'h200);
    step();
    chk("bp_pc_hold2", pc_ex, 32'h200);
    out_ready = 1'b1;
    step();
    chk("bp_pc_second", pc_ex, 32'h204);
    step();
    chk("bp_empty", out_valid, 0);
    chk("bp_count", taken.size(), 2);
    if (taken.size() == 2) begin
      chk("bp_first", taken[0], 32'h200);
      chk("bp_second", taken[1], 32'h204);
    end

    // Flush while full with a simultaneous incoming entry
    taken.delete();
    out_ready = 1'b0;
    send(32'h2A0); step();
    send(32'h2A4); step();
    send(32'h300); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_wb_en_ex", wb_en_ex, 0);
    chk("flush_in_ready", in_ready, 1);
    drain();
    found = 0;
    foreach (taken[i]) if (taken[i] == 32'h300) found++;
    chk("flush_dropped", found, 0);

    // Asynchronous reset between edges
    out_ready = 1'b0;
    send(32'h400); step();
    send(32'h404); step();
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_pc_ex", pc_ex, 0);
    chk("arst_wb_en_ex", wb_en_ex, 0);
    #2 rst = 1'b0;
    step();

`ifdef ID_EXE_WB_FWD_EN
    out_ready = 1'b0;
    send(32'h500); rs1_addr_id = 5'd5; rs1_data_id = 32'h11; rs2_addr_id = 5'd7;
    step();
    in_valid = 1'b0;
    wb_fwd_en = 1'b1; wb_fwd_addr = 5'd5; wb_fwd_data = 32'hDEAD;
    step();
    chk("fwd_hit", rs1_data_ex, 32'hDEAD);
    wb_fwd_addr = 5'd0; wb_fwd_data = 32'hBEEF;
    step();
    chk("fwd_zero", rs1_data_ex, 32'hDEAD);
    wb_fwd_en = 1'b0;
    drain();
`endif

    // Toggling out_ready with continuous input, 20 items
    taken.delete();
    n = 0;
    for (int cyc = 0; cyc < 200 && n < 20; cyc++) begin
      send(32'h1000 + 32'(4 * n));
      out_ready = cyc[0];
      if (in_ready) n++;
      step();
    end
    drain();
    chk("toggle_count", taken.size(), 20);
    for (int i = 0; i < 20 && i < taken.size(); i++)
      chk("toggle_order", taken[i], 32'h1000 + 32'(4 * i));

    // Random traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 1) == 1) send($urandom);
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
`ifdef ID_EXE_WB_FWD_EN
      wb_fwd_en   = ($urandom_range(0, 2) == 0);
      wb_fwd_addr = REG_AW'($urandom_range(0, 7));
      wb_fwd_data = $urandom;
`endif
      step();
    end
    flush = 1'b0;
`ifdef ID_EXE_WB_FWD_EN
    wb_fwd_en = 1'b0;
`endif
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_exe_pipe_reg.md
Name: id_exe_pipe_reg

Overview:
- Parametrised ID→EXE pipeline register; successor to the fixed 32-bit, always-advancing ID/EXE latch.
- Adds a valid/ready handshake, a 2-entry skid buffer so in_ready has no combinational path from out_ready, a synchronous flush (branch/trap) and optional write-back forwarding into held entries.
- Sits between the decode/register-file read stage and the execute stage.

Parameters:
- XLEN, 32, data width of rs1/rs2/imm/pc payload.
- REG_AW, 5, register address width (rd/rs1/rs2).
- CTRL_W, 8, opaque decoded-control bundle width, passed through untouched.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held and incoming entries.
- in_valid  in  1  ID payload valid.
- in_ready  out  1  stage can accept this cycle.
- wb_en_id  in  1  destination write enable.
- rd_addr_id  in  REG_AW  destination register.
- rs1_addr_id, rs2_addr_id  in  REG_AW  source registers (used for forwarding, also passed through).
- rs1_data_id, rs2_data_id  in  XLEN  register-file read data.
- imm_id, pc_id  in  XLEN  immediate, PC.
- ctrl_id  in  CTRL_W  control bundle.
- out_valid  out  1  EXE payload valid.
- out_ready  in  1  EXE consumes this cycle.
- wb_en_ex, rd_addr_ex, rs1_addr_ex, rs2_addr_ex, rs1_data_ex, rs2_data_ex, imm_ex, pc_ex, ctrl_ex  out  widths as above  registered payload.

Behaviour:
- Reset: all outputs are 0 except in_ready=1; state EMPTY; skid contents 0.
- Accept = in_valid & in_ready. Take = out_valid & out_ready.
- The main entry drives all outputs directly from flops. wb_en_ex = main.wb_en & out_valid, so it is never 1 while invalid. Other payload outputs hold their last value when invalid.
- in_ready = (state != FULL), decoded from state flops only.
- States EMPTY / ONE / FULL; out_valid = (state != EMPTY).
- EMPTY: accept → ONE, main ← in.
- ONE:
  - accept & take → ONE, main ← in.
  - accept & !take → FULL, skid ← in.
  - !accept & take → EMPTY.
  - otherwise hold.
- FULL: take → ONE, main ← skid; otherwise hold. Input is not accepted.
- Latency: 1 cycle from accept to out_valid when EMPTY, or ONE with take. Throughput is 1 per cycle with out_ready held high.
- Ordering is strictly FIFO; no payload is ever dropped or duplicated except by flush.
- flush has highest priority: next state EMPTY, out_valid 0 next cycle. A same-cycle accept is discarded, and upstream treats flush as killing its payload. A same-cycle take completes normally for EXE.
- Reset mid-operation: immediate asynchronous return to the reset values; no partial entry survives.

Optional Feature:
- Macro: ID_EXE_WB_FWD_EN.
- Enabled: adds ports wb_fwd_en (in, 1), wb_fwd_addr (in, REG_AW), wb_fwd_data (in, XLEN).
  - Each cycle, when wb_fwd_en=1 and wb_fwd_addr≠0, every occupied entry (main, skid) whose rs1_addr/rs2_addr matches has its rs1_data/rs2_data overwritten with wb_fwd_data.
  - An incoming entry being accepted is patched the same way before capture.
  - Both sources can match independently.
- Disabled: ports absent; data is captured as-is and held unchanged.

Decomposition:
- Package id_exe_pkg:
  - typedef struct packed id_ex_payload_t (wb_en, rd/rs1/rs2 addr, rs1/rs2 data, imm, pc, ctrl), parametrised through package localparams mirroring the defaults.
  - enum pipe_state_e {EMPTY, ONE, FULL}.
- One natural sub-module: id_exe_fwd_patch, a combinational function/module applying the forwarding overwrite to one payload. It is instantiated three times (in, main, skid) under the macro.

Test Plan:
- Streaming: out_ready=1, in_valid=1 for 4 cycles with pc 0x100, 0x104, 0x108, 0x10C → out_valid rises 1 cycle later; pc_ex shows the same sequence on consecutive cycles; in_ready stays 1.
- Backpressure: out_ready=0, send pc 0x200 then 0x204 → state FULL, in_ready=0, pc_ex=0x200 held. Release out_ready → outputs 0x200, then 0x204, then out_valid=0.
- Flush while FULL, with a simultaneous in_valid for pc 0x300 → next cycle out_valid=0, wb_en_ex=0, in_ready=1; 0x300 never appears.
- Async reset asserted mid-stream between clock edges → all outputs 0 and in_ready=1 immediately, without waiting for a clock edge.
- ID_EXE_WB_FWD_EN: hold an entry with rs1_addr=5 and rs1_data=0x11 under out_ready=0; pulse wb_fwd_en, addr 5, data 0xDEAD → rs1_data_ex=0xDEAD next cycle. Repeat with addr 0 → data unchanged.
- Mid-flow: out_ready toggling each cycle with continuous input for 20 items → output order and count match input exactly; wb_en_ex=0 whenever out_valid=0.
